// File: rtl/evt_crossbar_buf_if.sv
// Event crossbar bus: input event streams, routing matrix, output event streams and drop counter.
interface evt_crossbar_buf_if #(
  parameter int N_IN      = 8,
  parameter int N_OUT     = 8,
  parameter int EVT_WIDTH = 32
);
  logic [N_OUT-1:0][N_IN-1:0]      route_mask_i;
  logic [N_IN-1:0][EVT_WIDTH-1:0]  in_evt_i;
  logic [N_IN-1:0]                 in_valid_i;
  logic [N_IN-1:0]                 in_ready_o;
  logic [N_OUT-1:0][EVT_WIDTH-1:0] out_evt_o;
  logic [N_OUT-1:0]                out_valid_o;
  logic [N_OUT-1:0]                out_ready_i;
  logic [15:0]                     drop_cnt_o;

  modport slave (
    input  route_mask_i, in_evt_i, in_valid_i, out_ready_i,
    output in_ready_o, out_evt_o, out_valid_o, drop_cnt_o
  );
  modport master (
    output route_mask_i, in_evt_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_evt_o, out_valid_o, drop_cnt_o
  );
endinterface

// File: rtl/evt_crossbar_buf.sv
// Buffered multicast/merge event crossbar: per-output round-robin arbiter feeding a small FIFO,
// with per-input served masks so each multicast target completes independently.
module evt_xbar_oport #(
  parameter int N_IN       = 8,
  parameter int EVT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_IN-1:0]                 req_i,
  input  logic [N_IN-1:0][EVT_WIDTH-1:0]  evt_i,
  output logic [N_IN-1:0]                 gnt_o,
  output logic [EVT_WIDTH-1:0]            out_evt_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i
);
  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [EVT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d, idx, gidx;
  logic                 found, full, push, pop;

  assign full        = (cnt_q == CW'(FIFO_DEPTH));
  assign out_valid_o = (cnt_q != '0);
  assign out_evt_o   = mem_q[rd_q];
  assign pop         = out_valid_o && out_ready_i;

  // Scan requesters starting at ptr_q; first hit wins. A full FIFO blocks even when popping.
  always_comb begin
    gnt_o = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = PW'((int'(ptr_q) + k) % N_IN);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    push = found && !full;
    if (push) gnt_o[gidx] = 1'b1;
    ptr_d = ptr_q;
    if (push) ptr_d = (gidx == PW'(N_IN - 1)) ? '0 : gidx + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= evt_i[gidx];
  end
endmodule

module evt_crossbar_buf #(
  parameter int N_IN       = 8,
  parameter int N_OUT      = 8,
  parameter int EVT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  evt_crossbar_buf_if.slave bus
);
  logic [N_IN-1:0][N_OUT-1:0] served_q, served_d, targets, remaining, pushed;
  logic [N_OUT-1:0][N_IN-1:0] req, gnt;
  logic [N_OUT-1:0][EVT_WIDTH-1:0] out_evt;
  logic [N_OUT-1:0]           out_valid;
  logic [N_IN-1:0]            in_ready, drop;
  logic [15:0]                drop_q, drop_d;
  logic [16:0]                ndrop, drop_sum;

  always_comb begin
    targets   = '0;
    remaining = '0;
    req       = '0;
    for (int i = 0; i < N_IN; i++) begin
      for (int o = 0; o < N_OUT; o++) begin
        targets[i][o]   = bus.route_mask_i[o][i];
        remaining[i][o] = bus.route_mask_i[o][i] & ~served_q[i][o];
        req[o][i]       = bus.in_valid_i[i] & remaining[i][o];
      end
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_port
    evt_xbar_oport #(
      .N_IN(N_IN), .EVT_WIDTH(EVT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_port (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_i      (req[o]),
      .evt_i      (bus.in_evt_i),
      .gnt_o      (gnt[o]),
      .out_evt_o  (out_evt[o]),
      .out_valid_o(out_valid[o]),
      .out_ready_i(bus.out_ready_i[o])
    );
  end

  // An input completes once every still-targeted output has either been served or is pushed now.
  always_comb begin
    pushed   = '0;
    in_ready = '0;
    drop     = '0;
    served_d = served_q;
    ndrop    = '0;
    for (int i = 0; i < N_IN; i++) begin
      for (int o = 0; o < N_OUT; o++) pushed[i][o] = gnt[o][i];
      in_ready[i] = !rst_i && bus.in_valid_i[i] && ((remaining[i] & ~pushed[i]) == '0);
      drop[i]     = in_ready[i] && (targets[i] == '0);
      served_d[i] = in_ready[i] ? '0 : (served_q[i] | pushed[i]);
      ndrop       = ndrop + 17'(drop[i]);
    end
    drop_sum = {1'b0, drop_q} + ndrop;
    drop_d   = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      served_q <= '0;
      drop_q   <= '0;
    end else begin
      served_q <= served_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_evt_o   = out_evt;
  assign bus.out_valid_o = out_valid;
  assign bus.drop_cnt_o  = drop_q;
endmodule
